// File: rtl/base_vrotl_pipe.sv
// Pipelined variable-amount rotate-left with valid/ready flow control.
// One register stage per shift-amount bit; stage k applies the 2^(sw-1-k) term.
module base_vrotl_pipe #(
  parameter  int width     = 8,
  parameter  int tag_width = 1,
  localparam int sw        = (width > 1) ? $clog2(width) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:width-1]     i_d,
  input  logic [0:sw-1]        i_s,
  input  logic [0:tag_width-1] i_t,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:width-1]     o_d,
  output logic [0:tag_width-1] o_t
);

  typedef logic [0:width-1]     data_t;
  typedef logic [0:sw-1]        shift_t;
  typedef logic [0:tag_width-1] tag_t;

  // Stage registers
  logic   v_q [sw];
  data_t  d_q [sw];
  shift_t s_q [sw];
  tag_t   t_q [sw];

  // Stage inputs: stage 0 takes the ports, stage k takes stage k-1
  logic   in_v [sw];
  data_t  in_d [sw];
  shift_t in_s [sw];
  tag_t   in_t [sw];
  data_t  rot_d [sw];

  logic [sw-1:0] rdy;

  always_comb begin
    in_v[0] = i_v;
    in_d[0] = i_d;
    in_s[0] = i_s;
    in_t[0] = i_t;
    for (int k = 1; k < sw; k++) begin
      in_v[k] = v_q[k-1];
      in_d[k] = d_q[k-1];
      in_s[k] = s_q[k-1];
      in_t[k] = t_q[k-1];
    end
  end

  // Each stage has a fixed rotate amount, so the rotation is pure wiring plus a mux.
  for (genvar k = 0; k < sw; k++) begin : g_stage
    localparam int amt = (2 ** (sw - 1 - k)) % width;
    data_t rotated;
    for (genvar i = 0; i < width; i++) begin : g_bit
      assign rotated[i] = in_d[k][(i + amt) % width];
    end
    assign rot_d[k] = in_s[k][k] ? rotated : in_d[k];
  end

  // A stage may load when empty or when everything downstream of it can move.
  always_comb begin
    logic r;
    r   = o_r;
    rdy = '0;
    for (int k = sw - 1; k >= 0; k--) begin
      r      = r | ~v_q[k];
      rdy[k] = r;
    end
  end

  // NOTE: non-blocking assignments here so every stage samples the pre-edge
  // value of its upstream neighbour; blocking would collapse the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data/tag/shift registers are reset too, not just valids, so the
      // outputs never carry X even while o_v is low.
      for (int k = 0; k < sw; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        s_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < sw; k++) begin
        if (rdy[k]) begin
          v_q[k] <= in_v[k];
          if (in_v[k]) begin
            d_q[k] <= rot_d[k];
            s_q[k] <= in_s[k];
            t_q[k] <= in_t[k];
          end
        end
      end
    end
  end

  assign i_r = rdy[0];
  assign o_v = v_q[sw-1];
  assign o_d = d_q[sw-1];
  assign o_t = t_q[sw-1];

endmodule

// File: doc/base_vrotl_pipe.md
Name: base_vrotl_pipe

Overview:
- Pipelined, variable-amount rotate-left cell with valid/ready flow control.
- It is the inverse companion to the static right-rotator base_rotr: rotating left by s undoes base_rotr with rot=s.
- Used where a rotation amount arrives per-transaction, for example realigning lane-rotated data at the receive end of a datapath.
- Implemented as one registered stage per shift-amount bit, with an optional sideband tag carried alongside the data.

Parameters:
- width, 8: data width in bits; must be >= 1.
- tag_width, 1: width of the sideband tag carried unchanged; must be >= 1.
- sw, derived localparam = max(1, $clog2(width)): shift-amount width and pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input valid.
- i_r  output  1  input ready.
- i_d  input  [0:width-1]  data to rotate; bit 0 is leftmost.
- i_s  input  [0:sw-1]  rotate-left amount, unsigned; i_s[0] is the MSB.
- i_t  input  [0:tag_width-1]  sideband tag.
- o_v  output  1  output valid.
- o_r  input  1  output ready.
- o_d  output  [0:width-1]  rotated data.
- o_t  output  [0:tag_width-1]  tag, delayed with its data.

Behaviour:
- Function: o_d[i] = i_d[(i + s) mod width] for all i, with s = i_s. An amount >= width, possible when width is not a power of 2, rotates by s mod width.
- Transfer rules:
  - An input transfer occurs on a clk edge with i_v & i_r.
  - An output transfer occurs on a clk edge with o_v & o_r.
- Pipeline structure:
  - sw stages, k = 0 to sw-1. Each stage holds a valid bit, data, the remaining shift bits and the tag.
  - Stage k rotates left by (2^(sw-1-k)) mod width when shift bit i_s[k] of its transaction is 1, and passes the data through otherwise.
  - The rotated value is registered into stage k.
- Latency: a transfer accepted at edge n appears on o_v/o_d/o_t right after edge n+sw-1 when downstream never stalls. With sw=3 that is 3 register stages, so the output is visible 3 edges after acceptance counting acceptance as edge 1.
- Flow control:
  - Stage k may load when it is empty or its contents move downstream on the same edge: ready_k = ~v_k | ready_(k+1), where ready_sw = o_r.
  - i_r = ready_0. Ready is combinational from o_r through the chain; there is no combinational path from i_v to o_v.
- Throughput: one transfer per cycle sustained with o_r=1; no bubbles inserted.
- Backpressure: while o_v & ~o_r, o_d and o_t hold stable and o_v stays 1. Upstream stages fill and then deassert i_r.
- Simultaneous events: a stage that is both emptied and loaded on the same edge takes the new transaction; no data is lost or duplicated.
- width=1: every rotation is the identity; the block behaves as a 1-stage flow-controlled register.
- Reset (asynchronous, any time including mid-operation):
  - All stage valid bits clear, which gives o_v=0 immediately. Data, tag and shift registers clear to 0, which gives o_d=0 and o_t=0.
  - i_r=1 while reset is asserted and after it deasserts.
  - In-flight transactions are discarded.
- No X propagation: o_d and o_t are don't-care only when o_v=0, but they are still driven from reset-initialised registers.

Test Plan:
- Basic: width=8, i_d=8'b1000_0001, i_s=3'd1, o_r=1 -> after 3 stages o_d=8'b0000_0011, o_v high for exactly 1 cycle, o_t equals i_t.
- Sweep and inverse: width=8, random i_d, all s=0..7, streamed back-to-back with o_r=1 -> one output per cycle in order. Each o_d fed through base_rotr with rot=s reproduces i_d.
- Non-power-of-2: width=6, i_d=6'b100000, i_s=3'd7 -> o_d=6'b000001 (rotate by 1). With i_s=3'd6 -> o_d=i_d.
- Backpressure: stream 10 transactions, hold o_r=0 for 5 cycles mid-stream -> o_d/o_t stable while stalled, i_r drops after the 3 stages fill, all 10 results exit in order with none lost or duplicated.
- Reset mid-operation: 3 transactions in flight, assert reset asynchronously between edges -> o_v=0 and o_d=0 without waiting for an edge. After release i_r=1 and the next transaction completes correctly.
- width=1: toggle i_d with arbitrary i_s -> o_d equals i_d after 1 stage, with full valid/ready behaviour.
